spi_cfg_ctrl: RTL and testbench
===============================

Name: spi_cfg_ctrl

Overview:
- SPI slave configuration controller. An external host writes and reads a small bank of 8-bit config registers over SCLK/SSEL/MOSI/MISO.
- Writes land in shadow registers. Shadows are copied to the active bank only at frame start (vsync assertion), so pixel_color and audio blocks never see a mid-frame change.
- Sits beside hvsync_generator in demoscene_wrapper. Drives the cfg bus that configures the pixel and audio datapaths.

Parameters:
- NUM_REGS, 8, number of 8-bit config registers (1..128)
- VSYNC_ACTIVE, 1'b0, level of vsync during the sync pulse; commit fires on the transition into this level

Ports:
- clk  input  1  system/pixel clock
- reset  input  1  synchronous, active-high reset
- SCLK  input  1  SPI clock, asynchronous to clk, mode 0, must be at most clk/8
- SSEL  input  1  SPI slave select, active-low, asynchronous
- MOSI  input  1  SPI data in, MSB first, asynchronous
- MISO  output  1  SPI data out
- vsync  input  1  from hvsync_generator
- cfg_regs  output  NUM_REGS*8  active register bank; reg i occupies bits [8i+7:8i]
- cfg_update  output  1  one-cycle pulse when the active bank changed
- busy  output  1  high while a transaction is in progress (SSEL low, synced)

Behaviour:
- Input sync: SCLK, SSEL and MOSI each pass through a 2-FF synchronizer. A third stage on SCLK and SSEL provides edge detection. All protocol logic runs on detected edges in the clk domain.
- Frame format: byte0 = {rw, addr[6:0]} with rw=1 meaning write; byte1 = data. MSB first. MOSI is sampled on each detected SCLK rise.
- FSM states: IDLE, CMD, DATA, DONE.
  - IDLE -> CMD on synced SSEL fall; clear bit counter.
  - CMD: shift 8 bits. On the 8th rise latch rw/addr, then go to DATA.
  - DATA: shift 8 bits. On the 8th rise, if rw=1 and addr < NUM_REGS, write shadow[addr] and set dirty. Then go to DONE.
  - DONE: ignore further SCLK edges.
  - Any state -> IDLE on synced SSEL rise.
- Abort: SSEL rising before the 16th bit completes discards the transaction. No shadow write occurs.
- Out-of-range address: writes are ignored (dirty unchanged). Reads return 0x00.
- Read path: on the SCLK fall following the 8th rise, load a tx shift register with shadow[addr] (or 0x00) and drive bit7 on MISO. Each subsequent fall shifts the next bit out.
  - Reads return the shadow value, so a write is readable back immediately.
- MISO is 0 in IDLE, during CMD, in DONE, and throughout a write transaction.
- Commit: a vsync transition into VSYNC_ACTIVE (detected on registered vsync) with dirty=1 does the following in one cycle:
  - copy all shadows to the active bank;
  - clear dirty;
  - pulse cfg_update for exactly one cycle, coincident with the first cycle the new cfg_regs value is visible.
- No commit occurs if dirty=0 (no pulse).
- Simultaneous shadow write and commit in the same cycle: the commit copies the pre-write shadow contents. The write is stored and dirty stays 1, so the new value appears at the next frame.
- Reset (any time, including mid-transaction):
  - FSM -> IDLE; shadows and active bank = 0x00;
  - dirty=0, MISO=0, cfg_update=0, busy=0;
  - synchronizer flops -> idle levels (SSEL=1, SCLK=0).
  - The remainder of an interrupted transaction is ignored until SSEL goes high and then low again.
- busy = (state != IDLE).
- Latency: SSEL pin fall to busy high is 3 clk cycles. A write is visible on cfg_regs only after the next qualifying vsync edge, plus 1 clk.

Decomposition:
- Package demoscene_pkg holds:
  - register address constants (e.g. REG_COLOR_SEL=0, REG_SCROLL_X=1, REG_SCROLL_Y=2, REG_AUDIO_VOL=3, REG_MODE=4);
  - FSM state encoding;
  - CFG_W=8.
- One natural sub-module: spi_sync_edge. It contains the 3-flop synchronizer plus rise/fall pulse outputs, instantiated once each for SCLK and SSEL; MOSI uses its synced output only.

Test Plan:
1. Write 0x85 then 0x3C (write reg 5 = 0x3C) -> cfg_regs[47:40] stays 0x00 until the next vsync active edge. It then becomes 0x3C with a single cfg_update pulse in that same cycle.
2. Write reg 2 = 0xA5, then read 0x02 in the same frame -> MISO shifts 1010_0101 on data-byte SCLK rises. cfg_regs[23:16] is still 0x00 until vsync.
3. SSEL raised after 12 bits of write 0x81/0xFF -> shadow[1] unchanged, no cfg_update at the next vsync, FSM returns to IDLE.
4. Write addr 0x0A with NUM_REGS=8 -> no state change, dirty=0. A read of 0x0A returns 0x00 on MISO.
5. Shadow write completing on the same clk as the commit vsync edge -> active value unchanged this frame. The new value appears with cfg_update at the following vsync edge.
6. Assert reset midway through the data byte of a write to reg 3 -> cfg_regs all 0, busy=0, MISO=0. Remaining SCLK pulses are ignored, and the next full transaction after an SSEL cycle works.

Source files
------------

// File: rtl/demoscene_pkg.sv
// Shared definitions for the demoscene wrapper: config register map, SPI
// config FSM encoding and config bus width.
package demoscene_pkg;

    localparam int unsigned CFG_W = 8;

    localparam logic [6:0] REG_COLOR_SEL = 7'd0;
    localparam logic [6:0] REG_SCROLL_X  = 7'd1;
    localparam logic [6:0] REG_SCROLL_Y  = 7'd2;
    localparam logic [6:0] REG_AUDIO_VOL = 7'd3;
    localparam logic [6:0] REG_MODE      = 7'd4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmd  = 2'd1,
        StData = 2'd2,
        StDone = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchronizer for an asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the last two stages.
module spi_sync_edge #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= ResetVal;
            s2_q <= ResetVal;
            s3_q <= ResetVal;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign sync = s2_q;
    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/spi_cfg_ctrl.sv
// SPI slave config controller: host writes/reads shadow registers; shadows are
// copied to the active bank on a vsync edge so datapaths never see mid-frame changes.
module spi_cfg_ctrl
    import demoscene_pkg::*;
#(
    parameter int unsigned NUM_REGS     = 8,
    parameter logic        VSYNC_ACTIVE = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      SCLK,
    input  logic                      SSEL,
    input  logic                      MOSI,
    output logic                      MISO,
    input  logic                      vsync,
    output logic [NUM_REGS*CFG_W-1:0] cfg_regs,
    output logic                      cfg_update,
    output logic                      busy
);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic ssel_sync, ssel_rise, ssel_fall;

    spi_sync_edge #(.ResetVal(1'b0)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (SCLK),
        .sync  (sclk_sync),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.ResetVal(1'b1)) u_ssel_sync (
        .clk   (clk),
        .reset (reset),
        .din   (SSEL),
        .sync  (ssel_sync),
        .rise  (ssel_rise),
        .fall  (ssel_fall)
    );

    spi_state_e state_q, state_d;

    logic                      mosi_meta_q, mosi_sync_q;
    logic [1:0]                settle_q;
    logic                      armed_q;
    logic [2:0]                bit_cnt_q;
    logic [6:0]                shift_q;
    logic                      rw_q;
    logic [6:0]                addr_q;
    logic [CFG_W-1:0]          tx_q;
    logic                      tx_loaded_q;
    logic [CFG_W-1:0]          shadow_q [NUM_REGS];
    logic [NUM_REGS*CFG_W-1:0] shadow_flat;
    logic [NUM_REGS*CFG_W-1:0] active_q;
    logic                      dirty_q;
    logic                      cfg_update_q;
    logic                      vsync_q, vsync_prev_q;

    logic             start, shifting, last_bit, cmd_done, data_done;
    logic             addr_hit, wr_en, commit;
    logic [CFG_W-1:0] rx_byte, rd_val;

    // After reset SSEL must be seen high (once the synchronizer holds real pin
    // data) before a fall may open a transaction; a half-finished frame is skipped.
    // Mode 0 also requires SCLK idle low at frame start.
    assign start     = ssel_fall & armed_q & ~sclk_sync;
    assign shifting  = sclk_rise & ((state_q == StCmd) | (state_q == StData));
    assign last_bit  = sclk_rise & (bit_cnt_q == 3'd7);
    assign cmd_done  = (state_q == StCmd) & last_bit;
    assign data_done = (state_q == StData) & last_bit;
    assign rx_byte   = {shift_q, mosi_sync_q};
    assign addr_hit  = 32'(addr_q) < NUM_REGS;
    assign wr_en     = data_done & rw_q & addr_hit;
    assign commit    = (vsync_q == VSYNC_ACTIVE) & (vsync_prev_q != VSYNC_ACTIVE) & dirty_q;

    always_comb begin
        rd_val      = '0;
        shadow_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            shadow_flat[i*CFG_W +: CFG_W] = shadow_q[i];
            if (addr_q == 7'(i)) rd_val = shadow_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ssel_rise) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start) state_d = StCmd;
                StCmd:   if (last_bit) state_d = StData;
                StData:  if (last_bit) state_d = StDone;
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != StIdle);
        MISO = 1'b0;
        if ((state_q == StData) && !rw_q) MISO = tx_q[7];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            settle_q    <= 2'd0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            tx_q        <= '0;
            tx_loaded_q <= 1'b0;
        end else begin
            mosi_meta_q <= MOSI;
            mosi_sync_q <= mosi_meta_q;
            if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
            if ((settle_q == 2'd2) && ssel_sync) armed_q <= 1'b1;

            if (start) begin
                bit_cnt_q <= 3'd0;
            end else if (shifting) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                shift_q   <= {shift_q[5:0], mosi_sync_q};
            end

            if (cmd_done) begin
                rw_q        <= rx_byte[7];
                addr_q      <= rx_byte[6:0];
                tx_q        <= '0;
                tx_loaded_q <= 1'b0;
            end else if ((state_q == StData) && sclk_fall && !rw_q) begin
                // First fall after the command byte loads; later falls shift out.
                if (!tx_loaded_q) begin
                    tx_q        <= rd_val;
                    tx_loaded_q <= 1'b1;
                end else begin
                    tx_q <= {tx_q[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
            active_q     <= '0;
            dirty_q      <= 1'b0;
            cfg_update_q <= 1'b0;
            vsync_q      <= ~VSYNC_ACTIVE;
            vsync_prev_q <= ~VSYNC_ACTIVE;
        end else begin
            vsync_q      <= vsync;
            vsync_prev_q <= vsync_q;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_en && (addr_q == 7'(i))) shadow_q[i] <= rx_byte;
            end
            // A write landing with the commit is not copied; dirty stays set for it.
            if (commit) active_q <= shadow_flat;
            cfg_update_q <= commit;
            dirty_q      <= (dirty_q & ~commit) | wr_en;
        end
    end

    assign cfg_regs   = active_q;
    assign cfg_update = cfg_update_q;

endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// Self-checking bench for spi_cfg_ctrl: directed scenarios plus random SPI
// traffic compared against a shadow/active register model.
module tb_spi_cfg_ctrl;

    logic        clk;
    logic        reset;
    logic        SCLK;
    logic        SSEL;
    logic        MOSI;
    logic        MISO;
    logic        vsync;
    logic [63:0] cfg_regs;
    logic        cfg_update;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_shadow [8];
    logic [7:0] m_active [8];
    logic       m_dirty;

    spi_cfg_ctrl #(
        .NUM_REGS     (8),
        .VSYNC_ACTIVE (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .SCLK       (SCLK),
        .SSEL       (SSEL),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .vsync      (vsync),
        .cfg_regs   (cfg_regs),
        .cfg_update (cfg_update),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] active_flat();
        logic [63:0] f;
        for (int i = 0; i < 8; i++) f[i*8 +: 8] = m_active[i];
        return f;
    endfunction

    function automatic logic [7:0] model_read(input logic [6:0] a);
        return (a < 7'd8) ? m_shadow[a[2:0]] : 8'h00;
    endfunction

    function automatic void model_write(input logic [6:0] a, input logic [7:0] d);
        if (a < 7'd8) begin
            m_shadow[a[2:0]] = d;
            m_dirty          = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = 8'h00;
            m_active[i] = 8'h00;
        end
        m_dirty = 1'b0;
    endfunction

    // One SPI bit, mode 0: MISO captured as the host would at the SCLK rise.
    task automatic send_bit(input logic b, output logic m);
        MOSI = b;
        tick(4);
        m    = MISO;
        SCLK = 1'b1;
        tick(4);
        SCLK = 1'b0;
        tick(4);
    endtask

    task automatic xfer(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                        output logic [15:0] miso_w);
        logic [15:0] w;
        logic        m;
        w      = {b0, b1};
        miso_w = '0;
        SSEL   = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            send_bit(w[15-i], m);
            miso_w[15-i] = m;
        end
        SSEL = 1'b1;
        tick(6);
    endtask

    // Vsync pulse; commit expected on the second clk after the pin goes active.
    task automatic frame(input string tag);
        logic upd;
        logic exp_upd;
        vsync = 1'b0;
        tick(1);
        chk({tag, "_pre_regs"}, cfg_regs, active_flat());
        chk({tag, "_pre_upd"}, 64'(cfg_update), 64'd0);
        tick(1);
        upd     = cfg_update;
        exp_upd = m_dirty;
        if (m_dirty) begin
            for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
            m_dirty = 1'b0;
        end
        chk({tag, "_upd"}, 64'(upd), 64'(exp_upd));
        chk({tag, "_regs"}, cfg_regs, active_flat());
        tick(1);
        chk({tag, "_upd_end"}, 64'(cfg_update), 64'd0);
        vsync = 1'b1;
        tick(3);
    endtask

    initial begin
        logic [15:0] mw;
        logic [15:0] w;
        logic        m;
        logic [6:0]  a;
        logic [7:0]  d;
        int          op;
        int          nb;

        reset = 1'b1;
        SCLK  = 1'b0;
        SSEL  = 1'b1;
        MOSI  = 1'b0;
        vsync = 1'b1;
        model_reset();
        tick(4);
        reset = 1'b0;
        tick(6);

        chk("rst_regs", cfg_regs, 64'd0);
        chk("rst_upd", 64'(cfg_update), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_miso", 64'(MISO), 64'd0);

        // SSEL pin fall to busy: three clk cycles.
        SSEL = 1'b0;
        tick(2);
        chk("busy_lat2", 64'(busy), 64'd0);
        tick(1);
        chk("busy_lat3", 64'(busy), 64'd1);
        SSEL = 1'b1;
        tick(6);
        chk("busy_drop", 64'(busy), 64'd0);

        // Write reg 5 = 0x3C, held until vsync.
        xfer(8'h85, 8'h3C, 16, mw);
        model_write(7'd5, 8'h3C);
        chk("t1_miso_wr", 64'(mw), 64'd0);
        tick(20);
        chk("t1_reg5_hold", 64'(cfg_regs[47:40]), 64'h00);
        frame("t1_frame");
        chk("t1_reg5", 64'(cfg_regs[47:40]), 64'h3C);

        // Write reg 2 = 0xA5 then read it back in the same frame.
        xfer(8'h82, 8'hA5, 16, mw);
        model_write(7'd2, 8'hA5);
        xfer(8'h02, 8'h00, 16, mw);
        chk("t2_read", 64'(mw), 64'h00A5);
        chk("t2_reg2_hold", 64'(cfg_regs[23:16]), 64'h00);
        frame("t2_frame");

        // Abort after 12 bits: no write, no commit.
        xfer(8'h81, 8'hFF, 12, mw);
        chk("t3_busy", 64'(busy), 64'd0);
        xfer(8'h01, 8'h00, 16, mw);
        chk("t3_read", 64'(mw), {48'd0, 8'h00, model_read(7'd1)});
        frame("t3_frame");

        // Out-of-range address.
        xfer(8'h8A, 8'h5E, 16, mw);
        model_write(7'h0A, 8'h5E);
        xfer(8'h0A, 8'h00, 16, mw);
        chk("t4_read", 64'(mw), 64'h0000);
        frame("t4_frame");

        // Write completes on the same clk as the commit edge.
        xfer(8'h86, 8'h11, 16, mw);
        model_write(7'd6, 8'h11);
        w    = 16'h8622;
        SSEL = 1'b0;
        tick(4);
        for (int i = 0; i < 15; i++) send_bit(w[15-i], m);
        MOSI = w[0];
        tick(4);
        SCLK = 1'b1;
        tick(1);
        vsync = 1'b0;
        tick(2);
        for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
        m_dirty = 1'b0;
        model_write(7'd6, 8'h22);
        chk("t5_upd", 64'(cfg_update), 64'd1);
        chk("t5_regs", cfg_regs, active_flat());
        tick(1);
        chk("t5_upd_end", 64'(cfg_update), 64'd0);
        tick(2);
        SCLK = 1'b0;
        tick(4);
        SSEL = 1'b1;
        tick(6);
        vsync = 1'b1;
        tick(4);
        frame("t5_next");
        chk("t5_reg6", 64'(cfg_regs[55:48]), 64'h22);

        // Reset in the middle of the data byte of a write to reg 3.
        w    = 16'h835A;
        SSEL = 1'b0;
        tick(4);
        for (int i = 0; i < 12; i++) send_bit(w[15-i], m);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model_reset();
        tick(1);
        chk("t6_regs", cfg_regs, 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_miso", 64'(MISO), 64'd0);
        for (int i = 12; i < 16; i++) send_bit(w[15-i], m);
        chk("t6_busy_tail", 64'(busy), 64'd0);
        SSEL = 1'b1;
        tick(6);
        frame("t6_frame_nop");
        xfer(8'h83, 8'h5A, 16, mw);
        model_write(7'd3, 8'h5A);
        frame("t6_frame");
        chk("t6_reg3", 64'(cfg_regs[31:24]), 64'h5A);

        // Random traffic against the model.
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 9));
            a  = 7'($urandom_range(0, 15));
            d  = 8'($urandom);
            if (op <= 3) begin
                xfer({1'b1, a}, d, 16, mw);
                model_write(a, d);
                chk("rnd_wr_miso", 64'(mw), 64'd0);
            end else if (op <= 6) begin
                xfer({1'b0, a}, 8'($urandom), 16, mw);
                chk("rnd_rd", 64'(mw), {48'd0, 8'h00, model_read(a)});
            end else if (op == 7) begin
                nb = int'($urandom_range(1, 15));
                xfer({1'b1, a}, d, nb, mw);
                chk("rnd_abort_miso", 64'(mw), 64'd0);
                chk("rnd_abort_busy", 64'(busy), 64'd0);
            end else begin
                frame("rnd_frame");
            end
        end
        frame("final_frame");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
